// File: rtl/text_pkg.sv
// Shared definitions for the text display blocks: screen geometry defaults
// (also used by the video timing and character generator), the clear fill
// code, the recognised control codes and the writer state encoding.
package text_pkg;

  localparam int COLS_DEF   = 80;  // 640 px / 8
  localparam int ROWS_DEF   = 60;  // 480 px / 8
  localparam int ADDR_W_DEF = 13;

  localparam logic [7:0] FILL_CHR_DEF = 8'h20;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_t;

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream from a byte source into the console writer.
//   chr        character or control code
//   chr_valid  chr holds a valid code
//   chr_ready  writer accepts chr this cycle
// master = byte source, slave = console writer.
interface text_console_writer_if;
  logic [7:0] chr;
  logic       chr_valid;
  logic       chr_ready;

  modport master (output chr, output chr_valid, input chr_ready);
  modport slave  (input chr, input chr_valid, output chr_ready);
endinterface

// File: rtl/text_row_base.sv
// Tracks a physical text RAM row and its row*COLS base address without a
// multiplier: the base advances by COLS per row and both wrap to zero after
// the last row.
//   clk_i, rst_i   clock, synchronous active-high reset (row 0)
//   load_zero_i    force row/base to 0 (wins over inc_i)
//   inc_i          advance one row with wrap
//   base_o         current row*COLS
//   base_nxt_o     value base_o takes after this edge
module text_row_base import text_pkg::*; #(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_zero_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] base_o,
  output logic [ADDR_W-1:0] base_nxt_o
);

  localparam int ROW_W = $clog2(ROWS);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    row_d  = row_q;
    base_d = base_q;
    if (load_zero_i) begin
      row_d  = '0;
      base_d = '0;
    end else if (inc_i) begin
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_d  = '0;
        base_d = '0;
      end else begin
        row_d  = row_q + 1'b1;
        base_d = base_q + ADDR_W'(COLS);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q  <= '0;
      base_q <= '0;
    end else begin
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign base_o     = base_q;
  assign base_nxt_o = base_d;

endmodule

// File: rtl/text_console_writer.sv
// Writer side of the 8x8 text display. Takes character codes from a byte
// source, tracks the cursor, handles CR/LF/BS/FF and writes the dual-port
// text RAM. Scrolling moves top_row_o and clears only the exposed line.
//   clk_i, rst_i    clock, synchronous active-high reset
//   chr_if          character stream (slave side)
//   wr_en_o/addr/data  text RAM write port, addr = physical_row*COLS + col
//   top_row_o       physical RAM row shown at screen line 0
//   cur_col_o/row_o logical cursor position
//   busy_o          a clear sequence is running
//
// state       | meaning
// ST_IDLE     | waiting for a code; chr_ready high except the cycle after a transfer
// ST_PUT      | one-cycle character write, then cursor advance / wrap
// ST_CLR_LINE | filling the newly exposed physical row after a scroll
// ST_CLR_ALL  | filling the whole RAM (reset or form feed)
module text_console_writer import text_pkg::*; #(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter logic [7:0] FILL_CHR = FILL_CHR_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  text_console_writer_if.slave      chr_if,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [7:0]                wr_data_o,
  output logic [$clog2(ROWS)-1:0]   top_row_o,
  output logic [$clog2(COLS)-1:0]   cur_col_o,
  output logic [$clog2(ROWS)-1:0]   cur_row_o,
  output logic                      busy_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              ready_q, ready_d;

  logic              accept, newline, rb_inc, rb_load;
  logic [ADDR_W-1:0] rb_base, rb_base_nxt;

  // Base of the cursor's physical row, i.e. ((top+row) wrapped)*COLS. Every
  // newline moves it down one physical row, both on a plain row advance and
  // on a scroll (where the old top line becomes the cursor line).
  text_row_base #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_row_base (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_zero_i (rb_load),
    .inc_i       (rb_inc),
    .base_o      (rb_base),
    .base_nxt_o  (rb_base_nxt)
  );

  assign accept = chr_if.chr_valid && ready_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    newline = 1'b0;
    rb_inc  = 1'b0;
    rb_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (chr_if.chr)
            CHR_CR: col_d = '0;
            CHR_LF: newline = 1'b1;
            CHR_BS: if (col_q != '0) col_d = col_q - 1'b1;
            CHR_FF: begin
              state_d = ST_CLR_ALL;
              col_d   = '0;
              row_d   = '0;
              top_d   = '0;
              rb_load = 1'b1;
              wr_en_d = 1'b1;
              addr_d  = '0;
              data_d  = FILL_CHR;
              cnt_d   = ADDR_W'(COLS * ROWS - 1);
            end
            default: begin
              state_d = ST_PUT;
              wr_en_d = 1'b1;
              addr_d  = rb_base + ADDR_W'(col_q);
              data_d  = chr_if.chr;
            end
          endcase
        end
      end
      ST_PUT: begin
        if (col_q == COL_W'(COLS - 1)) begin
          col_d   = '0;
          newline = 1'b1;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CLR_LINE, ST_CLR_ALL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          wr_en_d = 1'b1;
          // Straight after reset no write has happened yet, so hold at 0.
          addr_d  = addr_q + ADDR_W'(wr_en_q);
          data_d  = FILL_CHR;
        end
      end
      default: state_d = ST_CLR_ALL;
    endcase

    if (newline) begin
      rb_inc = 1'b1;
      if (row_q != ROW_W'(ROWS - 1)) begin
        row_d   = row_q + 1'b1;
        state_d = ST_IDLE;
      end else begin
        top_d   = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + 1'b1;
        state_d = ST_CLR_LINE;
        wr_en_d = 1'b1;
        addr_d  = rb_base_nxt;
        data_d  = FILL_CHR;
        cnt_d   = ADDR_W'(COLS - 1);
      end
    end

    ready_d = (state_d == ST_IDLE) && !accept;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLR_ALL;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      cnt_q   <= ADDR_W'(COLS * ROWS);
      addr_q  <= '0;
      data_q  <= FILL_CHR;
      wr_en_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
    end
  end

  assign chr_if.chr_ready = ready_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign top_row_o = top_q;
  assign cur_col_o = col_q;
  assign cur_row_o = row_q;
  assign busy_o    = (state_q == ST_CLR_LINE) || (state_q == ST_CLR_ALL);

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  top_row, cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  always #5 clk = ~clk;

  text_console_writer_if cif();

  text_console_writer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .chr_if    (cif),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .top_row_o (top_row),
    .cur_col_o (cur_col),
    .cur_row_o (cur_row),
    .busy_o    (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: screen cursor, top row, and the list of RAM writes the
  // last transfer must produce, in order, starting at wr_start.
  typedef struct {
    int addr;
    int data;
    bit clr;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  m_col, m_row, m_top, wr_start, ready_at;
  bit  model_on = 1'b0;
  bit  w_exp;
  int  wr_cnt = 0, first_addr = -1, last_addr = -1, last_data = -1;

  task automatic push_clear_row(input int prow);
    for (int i = 0; i < COLS; i++) exp_q.push_back('{addr: prow * COLS + i, data: 32, clr: 1'b1});
  endtask

  task automatic model_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      push_clear_row(m_top);
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  // Reset takes effect at edge k+1; first clear write one cycle later.
  task automatic model_reset(input int k);
    exp_q.delete();
    m_col = 0; m_row = 0; m_top = 0;
    for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back('{addr: a, data: 32, clr: 1'b1});
    wr_start = k + 2;
    ready_at = k + 2 + COLS * ROWS;
    model_on = 1'b1;
    wr_cnt = 0;
  endtask

  // Transfer at edge n: writes are contiguous from cycle n, ready returns
  // the cycle after the last write (or after one idle cycle if none).
  task automatic model_accept(input int c, input int n);
    exp_q.delete();
    case (c)
      8'h0D: m_col = 0;
      8'h0A: model_newline();
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin
        m_col = 0; m_row = 0; m_top = 0;
        for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back('{addr: a, data: 32, clr: 1'b1});
      end
      default: begin
        exp_q.push_back('{addr: ((m_top + m_row) % ROWS) * COLS + m_col, data: c, clr: 1'b0});
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0;
          model_newline();
        end
      end
    endcase
    wr_start = n;
    ready_at = n + ((exp_q.size() > 0) ? exp_q.size() : 1);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(wr_addr);
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
      wr_cnt++;
    end
    if (model_on) begin
      w_exp = (cyc >= wr_start) && (exp_q.size() > 0);
      chk("wr_en", int'(wr_en), int'(w_exp));
      if (w_exp) begin
        e = exp_q.pop_front();
        if (wr_en === 1'b1) begin
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
        end
        chk("busy", int'(busy), int'(e.clr));
      end else begin
        chk("busy", int'(busy), int'(cyc < wr_start));
      end
      chk("ready", int'(cif.chr_ready), int'(cyc >= ready_at));
      if (cyc >= ready_at) begin
        chk("cur_col", int'(cur_col), m_col);
        chk("cur_row", int'(cur_row), m_row);
        chk("top_row", int'(top_row), m_top);
      end
    end
    if (rst) model_reset(cyc);
    else if (model_on && cif.chr_valid && cif.chr_ready) model_accept(int'(cif.chr), cyc + 1);
  end

  // Stimulus tasks start and end at #1 after a rising edge.
  task automatic send(input logic [7:0] c, input int gap);
    int t;
    if (gap > 0) begin
      cif.chr_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    cif.chr = c;
    cif.chr_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (cif.chr_ready !== 1'b1 && t < 6000);
    if (cif.chr_ready !== 1'b1) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    cif.chr_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (cif.chr_ready !== 1'b1 && t < 6000);
    if (cif.chr_ready !== 1'b1) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  int n0;
  int ff_left;
  int r, t;
  logic [7:0] c;

  initial begin
    cif.chr = 8'h00;
    cif.chr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    wait_idle();
    chk("rst_wr_count", wr_cnt, 4800);
    chk("rst_first_addr", first_addr, 0);
    chk("rst_last_addr", last_addr, 4799);
    chk("rst_last_data", last_data, 8'h20);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_row", int'(cur_row), 0);

    send(8'h41, 0);
    send(8'h42, 0);
    wait_idle();
    chk("ab_last_addr", last_addr, 1);
    chk("ab_last_data", last_data, 8'h42);
    chk("ab_col", int'(cur_col), 2);
    chk("ab_row", int'(cur_row), 0);

    send(8'h0D, 0);
    n0 = wr_cnt;
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(33, 126)), $urandom_range(0, 2));
    wait_idle();
    chk("wrap_last_addr", last_addr, 79);
    chk("wrap_writes", wr_cnt - n0, 80);
    chk("wrap_col", int'(cur_col), 0);
    chk("wrap_row", int'(cur_row), 1);

    for (int i = 0; i < 58; i++) send(8'h0A, $urandom_range(0, 1));
    wait_idle();
    chk("lf_row", int'(cur_row), 59);
    n0 = wr_cnt;
    send(8'h0A, 0);
    wait_idle();
    chk("scroll_top", int'(top_row), 1);
    chk("scroll_row", int'(cur_row), 59);
    chk("scroll_writes", wr_cnt - n0, 80);
    chk("scroll_last_addr", last_addr, 79);
    chk("scroll_last_data", last_data, 8'h20);
    send(8'h58, 0);
    wait_idle();
    chk("x_addr", last_addr, 0);
    chk("x_data", last_data, 8'h58);

    n0 = wr_cnt;
    send(8'h08, 0);
    send(8'h08, 0);
    wait_idle();
    chk("bs_col", int'(cur_col), 0);
    chk("bs_writes", wr_cnt - n0, 0);
    for (int i = 0; i < 37; i++) send(8'($urandom_range(33, 126)), 0);
    wait_idle();
    chk("col37", int'(cur_col), 37);
    n0 = wr_cnt;
    send(8'h0D, 1);
    wait_idle();
    chk("cr_col", int'(cur_col), 0);
    chk("cr_writes", wr_cnt - n0, 0);

    ff_left = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) c = 8'h0A;
      else if (r < 12) c = 8'h0D;
      else if (r < 16) c = 8'h08;
      else if (r == 16 && ff_left > 0) begin
        c = 8'h0C;
        ff_left--;
      end else if (r < 20) begin
        c = 8'($urandom_range(0, 31));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
      end else c = 8'($urandom_range(32, 255));
      send(c, $urandom_range(0, 3));
    end
    wait_idle();

    for (int i = 0; i < 60 && m_row != ROWS - 1; i++) send(8'h0A, 0);
    wait_idle();
    n0 = wr_cnt;
    send(8'h0A, 1);
    t = 0;
    while (wr_cnt < n0 + 20 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("clr_line_started", int'(wr_cnt >= n0 + 20), 1);
    @(posedge clk); #1;
    cif.chr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();
    chk("abort_wr_count", wr_cnt, 4800);
    chk("abort_first_addr", first_addr, 0);
    chk("abort_top", int'(top_row), 0);
    chk("abort_col", int'(cur_col), 0);
    chk("abort_row", int'(cur_row), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
